// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction-fetch sequencer with prefetch queue
//
// Purpose:
//   Owns the fetch PC, drives a word-addressed combinational-read instruction
//   memory every cycle, buffers fetched {pc, word} pairs in a circular
//   prefetch queue and presents the queue head to decode over valid/ready.
//   A redirect flushes the queue and restarts fetch; halt stops new fetches
//   while buffered entries keep draining.
//
// Parameters:
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset (word aligned)
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous active-high reset
//   imem_a          instruction memory byte address (word aligned)
//   imem_rd         instruction memory read data for imem_a
//   redirect        one-cycle pulse: flush queue, restart at redirect_pc
//   redirect_pc     new fetch address (bits [1:0] ignored)
//   halt            level: no new fetches while high
//   instr           instruction word at the queue head
//   instr_pc        byte address of instr
//   instr_valid     queue head is valid
//   instr_ready     decode accepts the head this cycle
//   q_count         current queue occupancy
//   perf_stall_cnt  (FETCH_PERF_EN only) saturating count of RUN cycles in
//                   which a fetch was blocked by a full queue with no pop
//
// Optional feature macro: FETCH_PERF_EN

module imem_fetch_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_a,
    input  logic [31:0]              imem_rd,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     halt,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_pc_mem   [DEPTH];
    logic [31:0]     r_word_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_hold_instr;
    logic [31:0]     r_hold_pc;

    logic            w_nonempty;
    logic            w_full;
    logic            w_pop;
    logic            w_fetch_ok;
    logic            w_push;
    logic            w_unused_rpc_lsbs;

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == FULL_CNT);

    // Redirect masks the head so a stale instruction is never accepted in
    // the flush cycle.
    assign instr_valid = w_nonempty & ~redirect;
    assign w_pop       = instr_valid & instr_ready;

    // Fetch is only legal in RUN; the cycle that sees halt already fetches nothing.
    assign w_fetch_ok = (r_state == S_RUN) & ~redirect & ~halt;
    // A full queue can still accept a word when the head leaves this cycle.
    assign w_push     = w_fetch_ok & (~w_full | w_pop);

    assign imem_a   = {r_fetch_pc[31:2], 2'b00};
    assign q_count  = r_count;

    // When the queue is empty the outputs show the last head that was
    // presented, so slots vacated by pops never leak onto the outputs.
    assign instr    = w_nonempty ? r_word_mem[r_rd_ptr] : r_hold_instr;
    assign instr_pc = w_nonempty ? r_pc_mem[r_rd_ptr]   : r_hold_pc;

    assign w_unused_rpc_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
            r_word_mem[r_wr_ptr] <= imem_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_BOOT;
            r_fetch_pc   <= RESET_PC;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            if (w_nonempty) begin
                r_hold_instr <= r_word_mem[r_rd_ptr];
                r_hold_pc    <= r_pc_mem[r_rd_ptr];
            end

            // Redirect freezes the state except out of BOOT.
            unique case (r_state)
                S_BOOT:   r_state <= halt ? S_HALTED : S_RUN;
                S_RUN:    if (halt && !redirect) r_state <= S_HALTED;
                S_HALTED: if (!halt && !redirect) r_state <= S_RUN;
                default:  r_state <= S_BOOT;
            endcase

            if (redirect) begin
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else begin
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + AW'(1);
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic w_stall;

    assign w_stall = w_fetch_ok & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
        end else if (w_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl

module tb_imem_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  q_count;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int n_vec;
    int n_err;

    imem_fetch_ctrl #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_a         (imem_a),
        .imem_rd        (imem_rd),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .q_count        (q_count)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Memory word i holds 0xE000_0000 + i.
    assign imem_rd = 32'hE000_0000 + {2'b00, imem_a[31:2]};

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return 32'hE000_0000 + {2'b00, pc[31:2]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first RUN cycle with an empty queue.
    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        halt     = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        instr_ready = 1'b1;
        step();
        step();
        #1;
        n_vec++;
        if ({instr_valid, q_count, imem_a, instr, instr_pc} !== {1'b0, 3'd0, 32'h0, 32'h0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_values: got v=%b cnt=%0d a=%h i=%h pc=%h want all zero",
                     instr_valid, q_count, imem_a, instr, instr_pc);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({instr_valid, q_count, imem_a} !== {1'b0, 3'd0, 32'h0}) begin
            n_err++;
            $display("FAIL boot_cycle: got v=%b cnt=%0d a=%h want v=0 cnt=0 a=0",
                     instr_valid, q_count, imem_a);
        end
        step();
        #1;
        n_vec++;
        if ({instr_valid, imem_a} !== {1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL first_run_cycle: got v=%b a=%h want v=0 a=0", instr_valid, imem_a);
        end
        step();
        for (int k = 0; k < 6; k++) begin
            #1;
            n_vec++;
            if ({instr_valid, instr_pc, instr, q_count} !==
                {1'b1, 32'(4 * k), 32'hE000_0000 + 32'(k), 3'd1}) begin
                n_err++;
                $display("FAIL boot_stream[%0d]: got v=%b pc=%h i=%h cnt=%0d want v=1 pc=%h i=%h cnt=1",
                         k, instr_valid, instr_pc, instr, q_count, 32'(4 * k), 32'hE000_0000 + 32'(k));
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int fill;
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            fill = (i < 4) ? i : 4;
            #1;
            n_vec++;
            if ({instr_valid, q_count, imem_a} !== {(i != 0), 3'(fill), 32'(4 * fill)}) begin
                n_err++;
                $display("FAIL bp_fill[%0d]: got v=%b cnt=%0d a=%h want v=%b cnt=%0d a=%h",
                         i, instr_valid, q_count, imem_a, (i != 0), fill, 32'(4 * fill));
            end
            step();
        end
        #1;
        n_vec++;
        if ({q_count, imem_a} !== {3'd4, 32'h10}) begin
            n_err++;
            $display("FAIL bp_full_hold: got cnt=%0d a=%h want cnt=4 a=00000010", q_count, imem_a);
        end
`ifdef FETCH_PERF_EN
        n_vec++;
        if (perf_stall_cnt !== 32'd6) begin
            n_err++;
            $display("FAIL bp_perf_stalls: got %0d want 6", perf_stall_cnt);
        end
`endif
        instr_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            n_vec++;
            if ({instr_valid, instr_pc, instr, q_count} !==
                {1'b1, 32'(4 * k), 32'hE000_0000 + 32'(k), 3'd4}) begin
                n_err++;
                $display("FAIL bp_drain[%0d]: got v=%b pc=%h i=%h cnt=%0d want v=1 pc=%h i=%h cnt=4",
                         k, instr_valid, instr_pc, instr, q_count, 32'(4 * k), 32'hE000_0000 + 32'(k));
            end
            step();
        end
`ifdef FETCH_PERF_EN
        #1;
        n_vec++;
        if (perf_stall_cnt !== 32'd6) begin
            n_err++;
            $display("FAIL bp_perf_after: got %0d want 6", perf_stall_cnt);
        end
`endif
    endtask

    task automatic test_redirect();
        instr_ready = 1'b0;
        do_reset();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        instr_ready = 1'b1;
        #1;
        n_vec++;
        if ({instr_valid, q_count} !== {1'b0, 3'd2}) begin
            n_err++;
            $display("FAIL redir_cycle: got v=%b cnt=%0d want v=0 cnt=2", instr_valid, q_count);
        end
        step();
        redirect = 1'b0;
        #1;
        n_vec++;
        if ({instr_valid, q_count, imem_a} !== {1'b0, 3'd0, 32'h100}) begin
            n_err++;
            $display("FAIL redir_flush: got v=%b cnt=%0d a=%h want v=0 cnt=0 a=00000100",
                     instr_valid, q_count, imem_a);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if ({instr_valid, instr_pc, instr} !==
                {1'b1, 32'h100 + 32'(4 * k), 32'hE000_0040 + 32'(k)}) begin
                n_err++;
                $display("FAIL redir_stream[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                         k, instr_valid, instr_pc, instr, 32'h100 + 32'(4 * k), 32'hE000_0040 + 32'(k));
            end
            step();
        end
    endtask

    task automatic test_halt();
        instr_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        halt        = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if ({instr_valid, instr_pc, q_count} !== {1'b1, 32'(4 * k), 3'(3 - k)}) begin
                n_err++;
                $display("FAIL halt_drain[%0d]: got v=%b pc=%h cnt=%0d want v=1 pc=%h cnt=%0d",
                         k, instr_valid, instr_pc, q_count, 32'(4 * k), 3 - k);
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if ({instr_valid, q_count, imem_a} !== {1'b0, 3'd0, 32'hC}) begin
                n_err++;
                $display("FAIL halt_frozen[%0d]: got v=%b cnt=%0d a=%h want v=0 cnt=0 a=0000000c",
                         k, instr_valid, q_count, imem_a);
            end
            step();
        end
        halt = 1'b0;
        step();
        #1;
        n_vec++;
        if ({instr_valid, imem_a} !== {1'b0, 32'hC}) begin
            n_err++;
            $display("FAIL halt_resume_fetch: got v=%b a=%h want v=0 a=0000000c", instr_valid, imem_a);
        end
        step();
        #1;
        n_vec++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'hC, 32'hE000_0003}) begin
            n_err++;
            $display("FAIL halt_resume_deliver: got v=%b pc=%h i=%h want v=1 pc=0000000c i=e0000003",
                     instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pcs [3];
        pcs[0] = 32'hFFFF_FFF8;
        pcs[1] = 32'hFFFF_FFFC;
        pcs[2] = 32'h0000_0000;
        instr_ready = 1'b1;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        #1;
        n_vec++;
        if ({instr_valid, imem_a} !== {1'b0, 32'hFFFF_FFF8}) begin
            n_err++;
            $display("FAIL wrap_addr: got v=%b a=%h want v=0 a=fffffff8", instr_valid, imem_a);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, pcs[k], exp_word(pcs[k])}) begin
                n_err++;
                $display("FAIL wrap_stream[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                         k, instr_valid, instr_pc, instr, pcs[k], exp_word(pcs[k]));
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        reset    = 1'b0;
        redirect = 1'b0;
        #1;
        n_vec++;
        if ({instr_valid, q_count, imem_a, instr, instr_pc} !== {1'b0, 3'd0, 32'h0, 32'h0, 32'h0}) begin
            n_err++;
            $display("FAIL mid_reset_values: got v=%b cnt=%0d a=%h i=%h pc=%h want all zero",
                     instr_valid, q_count, imem_a, instr, instr_pc);
        end
        instr_ready = 1'b1;
        step();
        step();
        #1;
        n_vec++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'hE000_0000}) begin
            n_err++;
            $display("FAIL mid_reset_restart: got v=%b pc=%h i=%h want v=1 pc=00000000 i=e0000000",
                     instr_valid, instr_pc, instr);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer that sits between the core's decode stage and the word-addressed, combinational-read instruction memory. It owns the fetch PC, drives the memory address every cycle, buffers fetched words with their PCs in a small prefetch queue, and hands them to decode over a valid/ready handshake. Branch redirects flush the queue, and a halt input freezes fetching without losing buffered instructions.

## Interface
- `DEPTH`, 4: prefetch queue entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `imem_a`  out  32  instruction memory byte address; always word aligned.
- `imem_rd`  in  32  instruction memory read data, valid combinationally for `imem_a`.
- `redirect`  in  1  one-cycle pulse; flush the queue and restart at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- `halt`  in  1  level; while high, no new fetches.
- `instr`  out  32  instruction word at the queue head.
- `instr_pc`  out  32  byte address of `instr`.
- `instr_valid`  out  1  queue head is valid.
- `instr_ready`  in  1  decode accepts the head this cycle.
- `q_count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State: `fetch_pc` (32b), circular queue of DEPTH × {pc, word}, read/write pointers, occupancy counter, FSM {BOOT, RUN, HALTED}.
- `imem_a = {fetch_pc[31:2], 2'b00}` combinationally, in every state.
- Pop: `pop = instr_valid & instr_ready`. Head advances at the clock edge.
- Push happens in RUN when `!redirect`, and either the queue is not full or `pop` is high. It writes `{fetch_pc, imem_rd}` at the tail and sets `fetch_pc += 4`, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- A full queue with a simultaneous pop pushes and pops in the same cycle. `q_count` is unchanged.
- An empty queue has no bypass. A word pushed in cycle N is visible at the outputs in cycle N+1.
- Redirect, which has priority over everything else:
  - Pointers and count are cleared.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - No push occurs.
  - `instr_valid` is forced to 0 combinationally in the redirect cycle, so no pop occurs.
  - Allowed in every state. The state does not change, except BOOT, which still moves to RUN.
- FSM:
  - BOOT: entered on reset, lasts one cycle with no fetch. Next state is HALTED if `halt`, else RUN.
  - RUN: fetches per the push rule. Goes to HALTED when `halt` = 1; no push occurs in that cycle.
  - HALTED: no push, pops continue, so the queue drains. Goes to RUN when `halt` = 0; fetching resumes at the next edge after that.
- Outputs:
  - `instr` and `instr_pc` are the head entry. They hold their last value when `instr_valid` = 0, and are 0 after reset.
  - `instr_valid = (q_count != 0) & !redirect`.

## Timing
- Reset values: `fetch_pc = RESET_PC`, `imem_a = RESET_PC`, `instr_valid = 0`, `instr = 0`, `instr_pc = 0`, `q_count = 0`, FSM = BOOT.
- Reset asserted mid-operation discards the queue contents and any pending redirect on that edge.
- First instruction after reset release: pushed in the cycle after BOOT, valid 2 cycles after the release edge.
- Redirect in cycle N: `imem_a = redirect_pc` in cycle N+1, push in N+1, valid in N+2. This is a 2-cycle redirect bubble.
- Sustained throughput: 1 instruction/cycle while `instr_ready` stays high.
- `q_count` never exceeds DEPTH. No push is attempted when full without a pop.

## Configuration
- `FETCH_PERF_EN`: when defined, adds output `perf_stall_cnt` (out, 32). It increments by 1 (saturating at 0xFFFF_FFFF) on every RUN cycle where a push was blocked because the queue was full without a pop. It resets to 0 and is not cleared by redirect.
- Without the macro, the port and counter do not exist and behaviour is otherwise identical.

## Test plan
- **Reset/boot:** memory word i = 0xE000_0000+i, ready held 1, release reset at edge 0. `instr_valid` rises at edge 2 with `instr_pc` = 0x0, 0x4, 0x8… and `instr` = 0xE000_0000, 0xE000_0001… on consecutive cycles.
- **Backpressure/full:** ready = 0 for 10 cycles. Requirements:
  - `q_count` saturates at 4.
  - `imem_a` holds 0x10.
  - `perf_stall_cnt` counts the blocked cycles (with the macro).
  - After ready = 1, the words at 0x0–0x10 come out in order with no gaps or duplicates.
- **Redirect:** redirect = 1 with `redirect_pc` = 0x0000_0103 while the queue is partially full. In that cycle valid = 0, and `q_count` = 0 next cycle. The next delivered `instr_pc` is 0x100, 2 cycles later, and no stale instruction is delivered.
- **Halt:** assert halt with 3 entries queued and ready = 1. The 3 entries drain, then valid stays 0 and `imem_a` is frozen. Deassert halt: fetch resumes at the frozen address.
- **Wrap-around and simultaneous events:**
  - Redirect to 0xFFFF_FFF8: sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
  - Full queue with pop and push in the same cycle: `q_count` stays 4.
  - Reset asserted mid-stream: all outputs at reset values on the next cycle.
